// File: rtl/muldiv_ctrl_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer: function codes,
// state encoding and the function-code decoder.
package muldiv_ctrl_pkg;

    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

    localparam int MULDIV_ITERS = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MUL   = 2'd1,
        DIV   = 2'd2,
        FIXUP = 2'd3
    } muldiv_state_t;

    typedef struct packed {
        logic hilo;       // any of the eight HI/LO-class codes
        logic start;      // launches an iterative operation
        logic is_signed;
        logic is_div;
        logic mthi;
        logic mtlo;
        logic mfhi;
        logic mflo;
    } fn_decode_t;

    function automatic fn_decode_t decode_fn(input logic [5:0] fn);
        fn_decode_t d;
        d           = '0;
        d.mfhi      = (fn == FUNCT_MFHI);
        d.mthi      = (fn == FUNCT_MTHI);
        d.mflo      = (fn == FUNCT_MFLO);
        d.mtlo      = (fn == FUNCT_MTLO);
        d.start     = (fn == FUNCT_MULT) || (fn == FUNCT_MULTU) ||
                      (fn == FUNCT_DIV)  || (fn == FUNCT_DIVU);
        d.is_signed = (fn == FUNCT_MULT) || (fn == FUNCT_DIV);
        d.is_div    = (fn == FUNCT_DIV)  || (fn == FUNCT_DIVU);
        d.hilo      = d.start | d.mfhi | d.mthi | d.mflo | d.mtlo;
        return d;
    endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// Request/result bundle between decode (master) and the mul/div sequencer (slave).
interface muldiv_ctrl_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  req;
    logic [5:0]            fncode;
    logic [DATA_WIDTH-1:0] op_a;
    logic [DATA_WIDTH-1:0] op_b;
    logic                  stall;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] hi;
    logic [DATA_WIDTH-1:0] lo;
    logic [DATA_WIDTH-1:0] mf_data;

    modport master (
        output req, fncode, op_a, op_b,
        input  stall, busy, done, hi, lo, mf_data
    );

    modport slave (
        input  req, fncode, op_a, op_b,
        output stall, busy, done, hi, lo, mf_data
    );
endinterface

// File: rtl/muldiv_ctrl_core.sv
// Unsigned iterative datapath: 64-bit accumulator shared by shift-add multiply
// (product shifts right) and restoring divide ({remainder, quotient} shifts left).
module muldiv_core #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic                    step,
    input  logic                    div_mode,
    input  logic [DATA_WIDTH-1:0]   a_in,
    input  logic [DATA_WIDTH-1:0]   b_in,
    output logic [2*DATA_WIDTH-1:0] acc
);
    localparam int W = DATA_WIDTH;

    logic [2*W-1:0] acc_q;
    logic [W-1:0]   opnd_q;   // multiplicand or divisor
    logic           div_q;

    logic [W-1:0]   addend;
    logic [W:0]     add_sum;
    logic [W:0]     trial;

    always_comb begin
        addend  = acc_q[0] ? opnd_q : {W{1'b0}};
        add_sum = {1'b0, acc_q[2*W-1:W]} + {1'b0, addend};
        // Shifted partial remainder minus divisor; bit W set means it went negative.
        trial   = acc_q[2*W-1:W-1] - {1'b0, opnd_q};
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    // NOTE: datapath registers are reset as well, so an operation aborted by
    // reset leaves no stale partial result behind.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q  <= '0;
            opnd_q <= '0;
            div_q  <= 1'b0;
        end else if (load) begin
            div_q  <= div_mode;
            opnd_q <= div_mode ? b_in : a_in;
            acc_q  <= {{W{1'b0}}, (div_mode ? a_in : b_in)};
        end else if (step) begin
            if (div_q) begin
                if (trial[W])
                    acc_q <= {acc_q[2*W-2:0], 1'b0};
                else
                    acc_q <= {trial[W-1:0], acc_q[W-2:0], 1'b1};
            end else begin
                acc_q <= {add_sum, acc_q[W-1:1]};
            end
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO sequencer: accepts MULT/DIV-class requests, runs 32 datapath iterations
// plus a sign fix-up cycle, owns HI/LO and stalls HI/LO requests while busy.
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic        clk,
    input  logic        reset,
    muldiv_ctrl_if.slave bus
);
    localparam int W     = DATA_WIDTH;
    localparam int CNT_W = $clog2(DATA_WIDTH) + 1;

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_MUL   = MUL;
    localparam logic [1:0] ST_DIV   = DIV;
    localparam logic [1:0] ST_FIXUP = FIXUP;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(MULDIV_ITERS - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             busy_q;
    logic             done_q;
    logic [W-1:0]     hi_q;
    logic [W-1:0]     lo_q;
    logic             op_div_q;
    logic             res_neg_q;
    logic             rem_neg_q;
    logic             div_zero_q;

    fn_decode_t       dec;
    logic             accept;
    logic             stepping;
    logic             stall;
    logic             a_neg;
    logic             b_neg;
    logic [W-1:0]     a_mag;
    logic [W-1:0]     b_mag;
    logic [2*W-1:0]   acc;
    logic [2*W-1:0]   prod_fix;
    logic [W-1:0]     quo_fix;
    logic [W-1:0]     rem_fix;
    logic [W-1:0]     mf_data;

    assign dec      = decode_fn(bus.fncode);
    assign accept   = (state == ST_IDLE) && bus.req && dec.start;
    assign stepping = (state == ST_MUL) || (state == ST_DIV);

    // Signed operations run on magnitudes; the signs are reapplied in FIXUP.
    always_comb begin
        a_neg = dec.is_signed & bus.op_a[W-1];
        b_neg = dec.is_signed & bus.op_b[W-1];
        a_mag = a_neg ? -bus.op_a : bus.op_a;
        b_mag = b_neg ? -bus.op_b : bus.op_b;
    end

    muldiv_core #(
        .DATA_WIDTH (W)
    ) u_core (
        .clk      (clk),
        .reset    (reset),
        .load     (accept),
        .step     (stepping),
        .div_mode (dec.is_div),
        .a_in     (a_mag),
        .b_in     (b_mag),
        .acc      (acc)
    );

    // Divide by zero leaves the dividend magnitude as remainder, so the normal
    // remainder fix-up restores op_a as presented; only the quotient is forced.
    always_comb begin
        prod_fix = res_neg_q ? -acc : acc;
        rem_fix  = rem_neg_q ? -acc[2*W-1:W] : acc[2*W-1:W];
        if (div_zero_q)
            quo_fix = {W{1'b1}};
        else
            quo_fix = res_neg_q ? -acc[W-1:0] : acc[W-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            op_div_q   <= 1'b0;
            res_neg_q  <= 1'b0;
            rem_neg_q  <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.req) begin
                        if (dec.start) begin
                            state      <= dec.is_div ? ST_DIV : ST_MUL;
                            busy_q     <= 1'b1;
                            cnt        <= '0;
                            op_div_q   <= dec.is_div;
                            res_neg_q  <= a_neg ^ b_neg;
                            rem_neg_q  <= a_neg;
                            div_zero_q <= dec.is_div && (bus.op_b == '0);
                        end else if (dec.mthi) begin
                            hi_q <= bus.op_a;
                        end else if (dec.mtlo) begin
                            lo_q <= bus.op_a;
                        end
                    end
                end
                ST_MUL, ST_DIV: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_ITER)
                        state <= ST_FIXUP;
                end
                ST_FIXUP: begin
                    if (op_div_q) begin
                        hi_q <= rem_fix;
                        lo_q <= quo_fix;
                    end else begin
                        {hi_q, lo_q} <= prod_fix;
                    end
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign stall = bus.req & busy_q & dec.hilo;

    // NOTE: mf_data gets a default before the conditional so no latch is inferred.
    always_comb begin
        mf_data = '0;
        if (bus.req && !stall) begin
            if (dec.mfhi)
                mf_data = hi_q;
            else if (dec.mflo)
                mf_data = lo_q;
        end
    end

    assign bus.stall   = stall;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.hi      = hi_q;
    assign bus.lo      = lo_q;
    assign bus.mf_data = mf_data;

endmodule
